ififo_ctrl: RTL and testbench

- Sequencer for the 8-column input FIFO bank that sits between activation SRAM and the PE array.
- On `start`, reads `len` activation vectors from SRAM and writes each into all column FIFOs (FILL).
- Then issues FIFO reads to the array in broadcast or staggered (diagonal) mode (DRAIN), and pulses `done` once the last column has been read.
- Owns `fifo_rd`, `fifo_rd_config` and `fifo_wr`; the FIFO bank itself is unchanged.

---
 rtl/ififo_ctrl_pkg.sv | 16 +
 rtl/ififo_ctrl_if.sv | 45 ++++
 rtl/ififo_ctrl.sv | 155 +++++++++++++++
 tb/tb_ififo_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ififo_ctrl_pkg.sv
// Shared types and defaults for the input-FIFO bank sequencer.
package ififo_ctrl_pkg;

    localparam int unsigned COL_DEF    = 8;
    localparam int unsigned DEPTH_DEF  = 16;
    localparam int unsigned TAIL_BCAST = 1;

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StDrain,
        StTail,
        StDone
    } ififo_ctrl_state_t;

endpackage

// File: rtl/ififo_ctrl_if.sv
// Handshake bundle between the sequencer, activation SRAM, FIFO bank and PE array.
// Carries stall_cnt only when IFIFO_CTRL_STALL_CNT_EN is defined.
interface ififo_ctrl_if
    import ififo_ctrl_pkg::*;
#(
    parameter int unsigned COL    = COL_DEF,
    parameter int unsigned LEN_W  = 5,
    parameter int unsigned ADDR_W = 11
) ();

    logic              start;
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] base_addr;
    logic              stagger;
    logic              mem_cen;
    logic [ADDR_W-1:0] mem_addr;
    logic [COL-1:0]    fifo_wr;
    logic              fifo_rd;
    logic              fifo_rd_config;
    logic              fifo_ready;
    logic              fifo_valid;
    logic              pe_ready;
    logic              busy;
    logic              done;
`ifdef IFIFO_CTRL_STALL_CNT_EN
    logic [15:0]       stall_cnt;
`endif

    modport master (
        input  start, len, base_addr, stagger, fifo_ready, fifo_valid, pe_ready,
        output mem_cen, mem_addr, fifo_wr, fifo_rd, fifo_rd_config, busy, done
`ifdef IFIFO_CTRL_STALL_CNT_EN
        , output stall_cnt
`endif
    );

    modport slave (
        output start, len, base_addr, stagger, fifo_ready, fifo_valid, pe_ready,
        input  mem_cen, mem_addr, fifo_wr, fifo_rd, fifo_rd_config, busy, done
`ifdef IFIFO_CTRL_STALL_CNT_EN
        , input stall_cnt
`endif
    );

endinterface

// File: rtl/ififo_ctrl.sv
// Input FIFO bank sequencer: fills all columns from SRAM, then drains to the PE array.
// Optional stall counter output enabled by IFIFO_CTRL_STALL_CNT_EN.
module ififo_ctrl
    import ififo_ctrl_pkg::*;
#(
    parameter int unsigned COL    = COL_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned LEN_W  = 5,
    parameter int unsigned ADDR_W = 11
) (
    input logic          clk,
    input logic          reset,
    ififo_ctrl_if.master bus
);

    localparam int unsigned      TAIL_W  = $clog2(COL + 1);
    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

    ififo_ctrl_state_t state_q;
    logic [LEN_W-1:0]  len_q;
    logic [ADDR_W-1:0] base_q;
    logic              stag_q;
    logic [LEN_W-1:0]  iss_q;
    logic [LEN_W-1:0]  wcnt_q;
    logic [LEN_W-1:0]  rcnt_q;
    logic [TAIL_W-1:0] tcnt_q;
    logic              wr_q;
    logic              cfg_q;
    logic              busy_q;
    logic              done_q;

    logic              issue;
    logic              rd;
    logic [LEN_W-1:0]  len_clamped;
    logic [TAIL_W-1:0] tail_last;
    logic [ADDR_W-1:0] addr;

    always_comb begin
        len_clamped = (bus.len > DEPTH_L) ? DEPTH_L : bus.len;
        issue       = (state_q == StFill) && (iss_q < len_q) && bus.fifo_ready;
        rd          = (state_q == StDrain) && bus.pe_ready && bus.fifo_valid &&
                      (rcnt_q < len_q);
        // Staggered reads need COL cycles for the diagonal to clear the last column.
        tail_last   = stag_q ? TAIL_W'(COL - 1) : TAIL_W'(TAIL_BCAST - 1);
        addr        = '0;
        if (issue) begin
            addr = base_q + ADDR_W'(iss_q);
        end
    end

    assign bus.mem_cen        = ~issue;
    assign bus.mem_addr       = addr;
    assign bus.fifo_wr        = {COL{wr_q}};
    assign bus.fifo_rd        = rd;
    assign bus.fifo_rd_config = cfg_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            len_q   <= '0;
            base_q  <= '0;
            stag_q  <= 1'b0;
            iss_q   <= '0;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            tcnt_q  <= '0;
            wr_q    <= 1'b0;
            cfg_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // SRAM data is valid one cycle after the read, so the write trails the issue.
            wr_q   <= issue;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        len_q  <= len_clamped;
                        base_q <= bus.base_addr;
                        stag_q <= bus.stagger;
                        cfg_q  <= ~bus.stagger;
                        busy_q <= 1'b1;
                        iss_q  <= '0;
                        wcnt_q <= '0;
                        rcnt_q <= '0;
                        tcnt_q <= '0;
                        if (len_clamped == '0) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StFill;
                        end
                    end
                end
                StFill: begin
                    if (issue) begin
                        iss_q <= iss_q + LEN_W'(1);
                    end
                    if (wr_q) begin
                        wcnt_q <= wcnt_q + LEN_W'(1);
                        if (wcnt_q + LEN_W'(1) == len_q) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (rd) begin
                        rcnt_q <= rcnt_q + LEN_W'(1);
                        if (rcnt_q + LEN_W'(1) == len_q) begin
                            state_q <= StTail;
                        end
                    end
                end
                StTail: begin
                    if (tcnt_q == tail_last) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end else begin
                        tcnt_q <= tcnt_q + TAIL_W'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef IFIFO_CTRL_STALL_CNT_EN
    logic [15:0] stall_q;
    logic        stall_inc;

    always_comb begin
        stall_inc = ((state_q == StFill) && !bus.fifo_ready) ||
                    ((state_q == StDrain) && !bus.pe_ready);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else if ((state_q == StIdle) && bus.start) begin
            stall_q <= '0;
        end else if (stall_inc && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign bus.stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_ififo_ctrl.sv
// Self-checking bench for ififo_ctrl: table-driven transactions with an address scoreboard.
module tb_ififo_ctrl;
    import ififo_ctrl_pkg::*;

    localparam int unsigned COL    = 8;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned LEN_W  = 5;
    localparam int unsigned ADDR_W = 11;
    localparam int          BUDGET = 300;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ififo_ctrl_if #(.COL(COL), .LEN_W(LEN_W), .ADDR_W(ADDR_W)) bus ();

    ififo_ctrl #(.COL(COL), .DEPTH(DEPTH), .LEN_W(LEN_W), .ADDR_W(ADDR_W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        int len;
        int base;
        bit stag;
        int fr_n;     // fifo_ready low cycles, starting after the first issue
        int pr_n;     // pe_ready low cycles, starting after the first read
        bit restart;  // pulse a second start after the first read
        int exp_n;
        int exp_lat;  // start cycle through done cycle, inclusive
        int exp_tail;
        int exp_cfg;
        int exp_stall;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_mem_cen"}, 32'(bus.mem_cen), 32'd1);
        check({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
        check({tag, "_fifo_wr"}, 32'(bus.fifo_wr), 32'd0);
        check({tag, "_fifo_rd"}, 32'(bus.fifo_rd), 32'd0);
        check({tag, "_rd_config"}, 32'(bus.fifo_rd_config), 32'd1);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
    endtask

    task automatic run(input string tag, input vec_t v);
        int exp_q[$];
        int niss = 0, nwr = 0, nwr_lo = 0, nrd = 0, bad_wr = 0, busy_bad = 0;
        int gap = 0, pend = 0, idle_act = 0;
        int first_iss = -1, first_wr = -1, first_rd = -1, last_rd = -1, done_cyc = -1;
        int fr_left = v.fr_n, pr_left = v.pr_n;
        logic cfg_rd = 1'b0;
        bit restarted = 1'b0;
        bit seen = 1'b0;
        logic [15:0] stall_at_done = '0;

        @(posedge clk); #1;
        bus.start      = 1'b1;
        bus.len        = LEN_W'(v.len);
        bus.base_addr  = ADDR_W'(v.base);
        bus.stagger    = v.stag;
        bus.fifo_ready = 1'b1;
        bus.pe_ready   = 1'b1;
        for (int i = 0; i < v.exp_n; i++) exp_q.push_back((v.base + i) % (1 << ADDR_W));
        @(posedge clk); #1;
        bus.start = 1'b0;

        for (int cyc = 1; cyc <= BUDGET && !seen; cyc++) begin
            if (cyc > 1) begin
                @(posedge clk); #1;
            end
            bus.fifo_ready = 1'b1;
            if (niss >= 1 && fr_left > 0) begin
                bus.fifo_ready = 1'b0;
                fr_left--;
            end
            bus.pe_ready = 1'b1;
            if (nrd >= 1 && pr_left > 0) begin
                bus.pe_ready = 1'b0;
                pr_left--;
            end
            bus.start = 1'b0;
            if (v.restart && nrd >= 1 && !restarted) begin
                bus.start     = 1'b1;
                bus.len       = LEN_W'(3);
                bus.base_addr = ADDR_W'('h123);
                bus.stagger   = ~v.stag;
                restarted     = 1'b1;
            end
            @(negedge clk);
            if (bus.mem_cen == 1'b0) begin
                niss++;
                if (first_iss < 0) first_iss = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL %s_extra_issue: got addr %0h expected no issue", tag,
                             bus.mem_addr);
                end else begin
                    check({tag, "_mem_addr"}, 32'(bus.mem_addr), exp_q.pop_front());
                end
            end
            if (bus.fifo_wr != '0) begin
                nwr++;
                if (first_wr < 0) first_wr = cyc;
                if (!bus.fifo_ready) nwr_lo++;
                if (bus.fifo_wr != 8'hFF) bad_wr++;
            end
            if (bus.fifo_rd) begin
                nrd++;
                if (first_rd < 0) begin
                    first_rd = cyc;
                    cfg_rd   = bus.fifo_rd_config;
                end
                last_rd = cyc;
                gap += pend;
                pend = 0;
            end else if (first_rd >= 0) begin
                pend++;
            end
            if (bus.busy !== 1'b1) busy_bad++;
            if (bus.done) begin
                seen     = 1'b1;
                done_cyc = cyc;
`ifdef IFIFO_CTRL_STALL_CNT_EN
                stall_at_done = bus.stall_cnt;
`endif
            end
        end
        bus.start = 1'b0;

        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) check({tag, "_latency"}, 32'(done_cyc + 1), 32'(v.exp_lat));
        check({tag, "_issues"}, 32'(niss), 32'(v.exp_n));
        check({tag, "_writes"}, 32'(nwr), 32'(v.exp_n));
        check({tag, "_reads"}, 32'(nrd), 32'(v.exp_n));
        check({tag, "_sb_left"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_wr_mask"}, 32'(bad_wr), 32'd0);
        check({tag, "_busy_hi"}, 32'(busy_bad), 32'd0);
        if (v.exp_n > 0) begin
            check({tag, "_wr_lag"}, 32'(first_wr - first_iss), 32'd1);
            check({tag, "_rd_config"}, 32'(cfg_rd), 32'(v.exp_cfg));
            check({tag, "_tail"}, 32'(done_cyc - last_rd - 1), 32'(v.exp_tail));
            check({tag, "_rd_gap"}, 32'(gap), 32'(v.pr_n));
            check({tag, "_inflight_wr"}, 32'(nwr_lo), 32'(v.fr_n > 0 ? 1 : 0));
        end
`ifdef IFIFO_CTRL_STALL_CNT_EN
        check({tag, "_stall_cnt"}, 32'(stall_at_done), 32'(v.exp_stall));
`endif

        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_idle_done"}, 32'(bus.done), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (!bus.mem_cen || bus.fifo_wr != '0 || bus.fifo_rd || bus.done) idle_act++;
        end
        check({tag, "_idle_quiet"}, 32'(idle_act), 32'd0);
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.len        = '0;
        bus.base_addr  = '0;
        bus.stagger    = 1'b0;
        bus.fifo_ready = 1'b1;
        bus.fifo_valid = 1'b1;
        bus.pe_ready   = 1'b1;

        //          len  base    stg fr pr rs  n  lat tail cfg stall
        vecs[0] = '{4,  'h010, 0, 0, 0, 0, 4,  12, 1, 1, 0};
        vecs[1] = '{16, 'h100, 1, 0, 0, 0, 16, 43, 8, 0, 0};
        vecs[2] = '{20, 'h7FC, 1, 0, 0, 0, 16, 43, 8, 0, 0};
        vecs[3] = '{8,  'h020, 0, 3, 2, 0, 8,  25, 1, 1, 5};
        vecs[4] = '{0,  'h300, 0, 0, 0, 0, 0,  2,  1, 1, 0};
        vecs[5] = '{6,  'h040, 1, 0, 2, 0, 6,  25, 8, 0, 2};
        vecs[6] = '{5,  'h055, 0, 0, 0, 1, 5,  14, 1, 1, 0};
        vecs[7] = '{3,  'h0A0, 1, 0, 0, 0, 3,  17, 8, 0, 0};

        #12;
        check_reset_vals("in_reset");
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("after_release");
`ifdef IFIFO_CTRL_STALL_CNT_EN
        check("reset_stall_cnt", 32'(bus.stall_cnt), 32'd0);
`endif

        for (int i = 0; i < 7; i++) begin
            run($sformatf("v%0d", i), vecs[i]);
        end

        // Abort mid-FILL: outputs must fall back without waiting for a clock edge.
        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.len       = LEN_W'(8);
        bus.base_addr = ADDR_W'('h200);
        bus.stagger   = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_pre_mem_cen", 32'(bus.mem_cen), 32'd0);
        check("abort_pre_rd_config", 32'(bus.fifo_rd_config), 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check_reset_vals("abort");
        @(posedge clk); #1;
        reset = 1'b1;
        run("post_reset", vecs[7]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
